// File: rtl/counter_pkg.sv
// Shared definitions for the counter/flip-flop library.
//   cnt_state_t        : down-counter control state (IDLE, RUN, DONE)
//   CNT_WIDTH_DEFAULT  : default counter width in bits
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

    localparam int unsigned CNT_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/sync_down_counter_if.sv
// Control/status bundle of the loadable down-counter.
//   master : drives load, din, en, auto; observes q, qb, tc, busy, done
//   slave  : the counter side of the same signals
interface sync_down_counter_if
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH_DEFAULT
);

    logic             load;
    logic [WIDTH-1:0] din;
    logic             en;
    logic             auto;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, din, en, auto,
        input  q, qb, tc, busy, done
    );

    modport slave (
        input  load, din, en, auto,
        output q, qb, tc, busy, done
    );

endinterface

// File: rtl/jkff_sync.sv
// JK flip-flop with synchronous active-high clear.
//   clk, clr : clock and synchronous clear (q=0, qb=1)
//   j, k     : 00 hold, 01 reset, 10 set, 11 toggle
//   q, qb    : true and complement outputs, both registered
module jkff_sync (
    input  logic clk,
    input  logic clr,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q  <= 1'b0;
            qb <= 1'b1;
        end else begin
            unique case ({j, k})
                2'b01: begin
                    q  <= 1'b0;
                    qb <= 1'b1;
                end
                2'b10: begin
                    q  <= 1'b1;
                    qb <= 1'b0;
                end
                2'b11: begin
                    q  <= ~q;
                    qb <= ~qb;
                end
                default: begin
                    q  <= q;
                    qb <= qb;
                end
            endcase
        end
    end

endmodule

// File: rtl/sync_down_counter.sv
// Loadable synchronous down-counter / interval timer built from JK flops.
//   clk  : rising-edge clock
//   clr  : synchronous active-high clear (q=0, reload=0, IDLE)
//   bus  : slave side of sync_down_counter_if
//          load/din load count and reload value, en enables counting,
//          auto selects reload at terminal count; q/qb count, tc one-cycle
//          terminal pulse, busy in RUN, done in DONE.
module sync_down_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 clr,
    sync_down_counter_if.slave   bus
);

    cnt_state_t       state_q;
    cnt_state_t       state_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             tc_q;
    logic             tc_d;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] qb_w;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] low_zero;

    // Bit i of a decrement toggles when every bit below it is zero.
    always_comb begin
        low_zero = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            low_zero[i] = ((q_w & ((WIDTH'(1) << i) - WIDTH'(1))) == '0);
        end
    end

    // Next state, terminal-count pulse and per-bit J/K drive.
    always_comb begin
        state_d  = state_q;
        tc_d     = 1'b0;
        reload_d = reload_q;
        j        = '0;
        k        = '0;
        if (bus.load) begin
            j        = bus.din;
            k        = ~bus.din;
            reload_d = bus.din;
            state_d  = (bus.din != '0) ? RUN : DONE;
        end else if ((state_q == RUN) && bus.en) begin
            if (q_w == WIDTH'(1)) begin
                tc_d = 1'b1;
                if (bus.auto) begin
                    // Reload directly from 1 so zero is never visible.
                    j = reload_q;
                    k = ~reload_q;
                end else begin
                    j       = '0;
                    k       = '1;
                    state_d = DONE;
                end
            end else begin
                j = low_zero;
                k = low_zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= (state_d == RUN);
            done_q   <= (state_d == DONE);
        end
    end

    // One JK flop per count bit; clr shares the synchronous clear.
    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
        jkff_sync u_ff (
            .clk (clk),
            .clr (clr),
            .j   (j[g]),
            .k   (k[g]),
            .q   (q_w[g]),
            .qb  (qb_w[g])
        );
    end

    assign bus.q    = q_w;
    assign bus.qb   = qb_w;
    assign bus.tc   = tc_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_sync_down_counter.sv
// Scoreboard bench for sync_down_counter: the driver updates a behavioural
// timer model per edge and queues the expected outputs; the monitor pops
// one entry after every rising edge and compares.
module tb_sync_down_counter;
    import counter_pkg::*;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] qb;
        logic         tc;
        logic         busy;
        logic         done;
    } exp_t;

    logic clk;
    logic clr;
    logic running;
    int   n_checks;
    int   n_pass;
    exp_t exp_q[$];

    // Behavioural model: 0 = idle, 1 = run, 2 = done
    int unsigned m_cnt;
    int unsigned m_rel;
    int          m_mode;
    logic        m_tc;

    sync_down_counter_if #(.WIDTH(W)) bus ();

    sync_down_counter #(.WIDTH(W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Drive one edge's inputs, advance the model, queue the expectation.
    task automatic step(input logic c, input logic l, input logic [W-1:0] d,
                        input logic e, input logic a);
        exp_t x;
        clr      = c;
        bus.load = l;
        bus.din  = d;
        bus.en   = e;
        bus.auto = a;
        m_tc     = 1'b0;
        if (c) begin
            m_cnt  = 0;
            m_rel  = 0;
            m_mode = 0;
        end else if (l) begin
            m_cnt  = int'(d);
            m_rel  = int'(d);
            m_mode = (d != 0) ? 1 : 2;
        end else if (m_mode == 1 && e) begin
            if (m_cnt == 1) begin
                m_tc = 1'b1;
                if (a) m_cnt = m_rel;
                else begin
                    m_cnt  = 0;
                    m_mode = 2;
                end
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        x.q    = W'(m_cnt);
        x.qb   = ~W'(m_cnt);
        x.tc   = m_tc;
        x.busy = (m_mode == 1);
        x.done = (m_mode == 2);
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic run_en(input int n, input logic a);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'(0), 1'b1, a);
    endtask

    // Monitor: compare every output after each rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (running) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL queue: no expectation queued for this edge");
                end else begin
                    x = exp_q.pop_front();
                    check("q",    16'(bus.q),    16'(x.q));
                    check("qb",   16'(bus.qb),   16'(x.qb));
                    check("tc",   16'(bus.tc),   16'(x.tc));
                    check("busy", 16'(bus.busy), 16'(x.busy));
                    check("done", 16'(bus.done), 16'(x.done));
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        running  = 1'b1;
        m_cnt    = 0;
        m_rel    = 0;
        m_mode   = 0;

        // Reset, then ignored enable in IDLE
        step(1'b1, 1'b0, W'(0), 1'b0, 1'b0);
        step(1'b1, 1'b0, W'(0), 1'b1, 1'b0);
        run_en(3, 1'b0);

        // One-shot from 5, then 10 cycles parked at zero
        step(1'b0, 1'b1, W'(5), 1'b1, 1'b0);
        run_en(15, 1'b0);

        // Auto-reload divide-by-3
        step(1'b0, 1'b1, W'(3), 1'b1, 1'b1);
        run_en(12, 1'b1);

        // Full-range reload value
        step(1'b0, 1'b1, W'(15), 1'b1, 1'b1);
        run_en(32, 1'b1);

        // Enable gap at q=2
        step(1'b0, 1'b1, W'(4), 1'b1, 1'b0);
        run_en(2, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, W'(0), 1'b0, 1'b0);
        run_en(3, 1'b0);

        // Load zero, then load during a terminal-count cycle
        step(1'b0, 1'b1, W'(0), 1'b1, 1'b0);
        run_en(3, 1'b0);
        step(1'b0, 1'b1, W'(2), 1'b1, 1'b1);
        run_en(1, 1'b1);
        step(1'b0, 1'b1, W'(2), 1'b1, 1'b1);
        run_en(4, 1'b1);

        // Clear mid-count at 6, enable ignored afterwards
        step(1'b0, 1'b1, W'(9), 1'b1, 1'b0);
        run_en(3, 1'b0);
        step(1'b1, 1'b0, W'(0), 1'b1, 1'b0);
        run_en(5, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            logic         c, l, e, a;
            logic [W-1:0] d;
            c = ($urandom_range(0, 99) < 2);
            l = ($urandom_range(0, 99) < 8);
            e = ($urandom_range(0, 99) < 75);
            a = ($urandom_range(0, 99) < 50);
            d = ($urandom_range(0, 99) < 30) ? W'($urandom_range(0, 2))
                                             : W'($urandom_range(0, 15));
            step(c, l, d, e, a);
        end

        running = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_down_counter.md
# sync_down_counter

Synchronous, loadable down-counter/timer: the counting-down counterpart to the team's ripple up-counter. Loads a start value, decrements once per enabled clock, and flags terminal count with a one-cycle `tc` pulse. In one-shot mode it then stops at zero; in auto-reload mode it runs as a divide-by-N. Used as the interval timer and clock divider beside the up-counter in the counter/flip-flop library.

## Interface
- `WIDTH`, default 4: counter width in bits; 2 ≤ WIDTH ≤ 16.
- `clk`  in  1  clock; all state changes occur on the rising edge.
- `clr`  in  1  reset; synchronous and active-high.
- `load`  in  1  captures `din` into the count and into the reload register.
- `din`  in  WIDTH  start/reload value.
- `en`  in  1  count enable; decrements when high and in RUN.
- `auto`  in  1  1 = auto-reload at terminal count; 0 = one-shot. Sampled at the terminal-count edge.
- `q`  out  WIDTH  current count.
- `qb`  out  WIDTH  bitwise complement of `q`, always.
- `tc`  out  1  registered terminal-count pulse, exactly one cycle wide.
- `busy`  out  1  high when state is RUN.
- `done`  out  1  high when state is DONE.

## Operation
- Reset is synchronous and active-high. While `clr` is high at an edge: `q`=0, `qb`=all ones, reload register=0, `tc`=0, state=IDLE, `busy`=0, `done`=0.
- Priority at each edge: `clr` > `load` > decrement.
- States:
  - IDLE: `q` holds. `en` is ignored. Only `load` leaves IDLE.
  - RUN: active counting.
  - DONE: `q` holds 0. `en` is ignored. Only `load` or `clr` leaves DONE.
- `load` in any state: `q`←`din`, reload←`din`, `tc`←0. The next state is RUN if `din`≠0, otherwise DONE. A load of 0 never pulses `tc`.
- RUN with `en`=1:
  - If `q`>1: `q`←`q`−1.
  - If `q`=1 and `auto`=0: `q`←0, `tc`←1, next state DONE.
  - If `q`=1 and `auto`=1: `q`←reload, `tc`←1, stay in RUN. Zero is never visible in this case, so the count period is exactly reload cycles.
- RUN with `en`=0: `q` holds and `tc`←0.
- `tc` is 0 on every edge not listed above.
- Arithmetic is unsigned modulo 2^WIDTH. Decrement from 0 cannot occur because RUN always has `q`≥1. A reload value of 2^WIDTH−1 is legal.

## Timing
- `load` to `q` valid: 1 cycle (visible after the loading edge).
- With `en` held high after loading N, `tc` is high during cycle N after the load edge. In auto mode it repeats every N cycles, with no gap cycle.
- `load` asserted in the same cycle as a terminal-count decrement: the load wins and `tc` stays 0.
- `clr` mid-count: takes effect at that edge. A pending `tc` is suppressed.
- `qb`, `busy` and `done` change on the same edge as `q` and the state.

## Structure
- Shared package `counter_pkg`:
  - state enum `cnt_state_t` {IDLE, RUN, DONE};
  - `CNT_WIDTH_DEFAULT` = 4.
- Sub-module `jkff_sync`: a JK flip-flop with synchronous active-high clear and `q`/`qb` outputs. Instantiate one per count bit.
  - Decrement: bit i toggles (J=K=1) when decrementing and all lower bits are 0.
  - Load and reload: drive J=value, K=~value.
- The FSM and the reload register live in the top module.

## Test plan
- Reset, then `load` `din`=5 with `en`=1 and `auto`=0 → `q` reads 5,4,3,2,1,0. `tc`=1 only on the cycle `q` becomes 0. `done`=1, and `q` stays 0 for 10 more cycles.
- `auto`=1, `load` 3, `en`=1 for 12 cycles → `q` repeats 3,2,1,3,2,1,…. `tc` pulses every 3rd cycle, 4 pulses total, and `q` never reads 0.
- WIDTH=4, `load` 15, `auto`=1 → full 15-cycle period with a single `tc` per period. `qb` always equals ~`q`.
- `load` 4, toggle `en` low for 3 cycles after `q`=2 → `q` holds at 2 and `tc` stays 0. `tc` fires 2 enabled cycles after `en` returns high.
- `load` 0 → `q`=0, `done`=1, and `tc` never pulses. Then `load` 2 during a terminal-count cycle with `q`=1 → `q`=2 and no `tc`.
- Assert `clr` while `q`=6 in RUN → next cycle `q`=0, `qb`=4'hF, IDLE. `en` is then ignored until the next `load`.
